// File: rtl/prog_mem_responder_pkg.sv
// Shared types and constants for the program-memory responder: word width,
// loader FSM states and the default MMIO addresses.
package prog_mem_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } ldState_t;

  localparam word_t MMIO_OUT_ADDR = 16'hFFFF;
  localparam word_t MMIO_CYC_ADDR = 16'hFFFE;

endpackage

// File: rtl/prog_mem_responder_if.sv
// CPU instruction/data address bus plus the program-loader valid/ready stream.
// The bidirectional data bus DD is a plain inout port on the responder.
interface prog_mem_responder_if;
  import prog_mem_pkg::*;

  word_t IA;
  word_t ID;
  word_t DA;
  logic  RW;
  logic  LD_START;
  logic  LD_VALID;
  word_t LD_DATA;
  logic  LD_LAST;
  logic  LD_READY;

  modport master (
    output IA, DA, RW, LD_START, LD_VALID, LD_DATA, LD_LAST,
    input  ID, LD_READY
  );

  modport slave (
    input  IA, DA, RW, LD_START, LD_VALID, LD_DATA, LD_LAST,
    output ID, LD_READY
  );

endinterface

// File: rtl/prog_mem_responder_loader.sv
// Program-loader FSM: streams image words into the array and holds the CPU
// in reset until the image is complete.
module prog_loader_fsm
  import prog_mem_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          start_i,
  input  logic          valid_i,
  input  logic          last_i,
  output logic          ready_o,
  output logic          done_o,
  output logic          cpuRst_o,
  output logic          we_o,
  output logic [AW-1:0] addr_o
);

  ldState_t      state_q;
  logic [AW-1:0] cnt_q;
  logic          done_q;
  logic          cpuRst_q;
  logic [AW-1:0] cnt_d;

  assign cnt_d = cnt_q + AW'(1);

  // done/cpuRst are registered next to the state so they change on the same edge
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      cpuRst_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= LOAD;
            cnt_q   <= '0;
          end
        end
        LOAD: begin
          if (start_i) begin
            cnt_q <= '0;
          end else if (valid_i) begin
            cnt_q <= cnt_d;
            if (last_i || (cnt_q == {AW{1'b1}})) begin
              state_q  <= RUN;
              done_q   <= 1'b1;
              cpuRst_q <= 1'b0;
            end
          end
        end
        RUN: begin
          if (start_i) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            cpuRst_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          done_q   <= 1'b0;
          cpuRst_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o  = (state_q == LOAD);
  assign we_o     = (state_q == LOAD) && valid_i;
  assign addr_o   = cnt_q;
  assign done_o   = done_q;
  assign cpuRst_o = cpuRst_q;

endmodule

// File: rtl/prog_mem_responder.sv
// Unified instruction/data memory beside the 16-bit CPU, with program loader.
// Optional MMIO output register and cycle counter: define MMIO_REG_EN.
module prog_mem_responder
  import prog_mem_pkg::*;
#(
  parameter int AW = 8
`ifdef MMIO_REG_EN
  ,
  parameter word_t MMIO_OUT = MMIO_OUT_ADDR,
  parameter word_t MMIO_CYC = MMIO_CYC_ADDR
`endif
) (
  input  logic                CK,
  input  logic                RST,
  prog_mem_responder_if.slave bus,
  inout  wire  [WORD_W-1:0]   DD,
  output logic                LD_DONE,
  output logic                CPU_RST
`ifdef MMIO_REG_EN
  ,
  output word_t               OUT_REG
`endif
);

  localparam int DEPTH = 1 << AW;

  word_t         mem_q [DEPTH];
  logic          ldWe;
  logic          ldReady;
  logic [AW-1:0] ldAddr;
  logic [AW-1:0] iaIdx;
  logic [AW-1:0] daIdx;
  logic          cpuWrite;
  logic          memWrite;
  word_t         rdData;
  logic          unusedAddrBits;

  prog_loader_fsm #(.AW(AW)) uLoader (
    .CK       (CK),
    .RST      (RST),
    .start_i  (bus.LD_START),
    .valid_i  (bus.LD_VALID),
    .last_i   (bus.LD_LAST),
    .ready_o  (ldReady),
    .done_o   (LD_DONE),
    .cpuRst_o (CPU_RST),
    .we_o     (ldWe),
    .addr_o   (ldAddr)
  );

  assign bus.LD_READY   = ldReady;
  assign iaIdx          = bus.IA[AW-1:0];
  assign daIdx          = bus.DA[AW-1:0];
  assign unusedAddrBits = ^{bus.IA[WORD_W-1:AW], bus.DA[WORD_W-1:AW]};

  // LD_DONE is high exactly in RUN, so it gates CPU writes
  assign cpuWrite = LD_DONE && !bus.RW;

`ifdef MMIO_REG_EN
  logic  hitOut;
  logic  hitCyc;
  word_t outReg_q;
  word_t outReg_d;
  word_t cyc_q;
  word_t cyc_d;

  assign hitOut   = (bus.DA == MMIO_OUT);
  assign hitCyc   = (bus.DA == MMIO_CYC);
  assign memWrite = cpuWrite && !hitOut && !hitCyc;

  always_comb begin
    outReg_d = outReg_q;
    cyc_d    = cyc_q;
    if (cpuWrite && hitOut) outReg_d = DD;
    if (LD_DONE) cyc_d = cyc_q + 16'd1;
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      outReg_q <= '0;
      cyc_q    <= '0;
    end else begin
      outReg_q <= outReg_d;
      cyc_q    <= cyc_d;
    end
  end

  assign OUT_REG = outReg_q;

  always_comb begin
    rdData = mem_q[daIdx];
    if (hitOut)      rdData = outReg_q;
    else if (hitCyc) rdData = cyc_q;
  end
`else
  assign memWrite = cpuWrite;

  always_comb begin
    rdData = mem_q[daIdx];
  end
`endif

  // Loader and CPU never write together: one needs LOAD, the other RUN
  always_ff @(posedge CK) begin
    if (ldWe) begin
      mem_q[ldAddr] <= bus.LD_DATA;
    end else if (memWrite) begin
      mem_q[daIdx] <= DD;
    end
  end

  assign bus.ID = mem_q[iaIdx];
  assign DD     = bus.RW ? rdData : {WORD_W{1'bz}};

endmodule

// File: tb/tb_prog_mem_responder.sv
// Self-checking bench for prog_mem_responder against a word-array reference model.
// Covers the MMIO_REG_EN features when that macro is defined.
module tb_prog_mem_responder;
  import prog_mem_pkg::*;

  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic CK  = 1'b0;
  logic RST = 1'b1;
  always #5 CK = ~CK;

  prog_mem_responder_if bus ();

  wire  [15:0] DD;
  logic [15:0] tbDd;
  logic        LD_DONE;
  logic        CPU_RST;
`ifdef MMIO_REG_EN
  logic [15:0] OUT_REG;
`endif

  // The bench only drives DD while the CPU is writing
  assign DD = bus.RW ? 16'hzzzz : tbDd;

  prog_mem_responder #(.AW(AW)) dut (
    .CK      (CK),
    .RST     (RST),
    .bus     (bus),
    .DD      (DD),
    .LD_DONE (LD_DONE),
    .CPU_RST (CPU_RST)
`ifdef MMIO_REG_EN
    ,
    .OUT_REG (OUT_REG)
`endif
  );

  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] refMem [DEPTH];
  int          refCnt = 0;
  bit          refRun = 1'b0;
  logic [15:0] refOut = 16'h0000;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic startLoad();
    bus.LD_START = 1'b1;
    tick();
    bus.LD_START = 1'b0;
    refCnt = 0;
    refRun = 1'b0;
  endtask

  // One loader word, offered after 'gap' idle cycles and accepted immediately
  task automatic applyStimulus(input logic [15:0] data, input bit last, input int gap);
    repeat (gap) tick();
    bus.LD_VALID = 1'b1;
    bus.LD_DATA  = data;
    bus.LD_LAST  = last;
    tick();
    bus.LD_VALID = 1'b0;
    bus.LD_LAST  = 1'b0;
    refMem[refCnt] = data;
    refCnt++;
    if (last || refCnt == DEPTH) refRun = 1'b1;
  endtask

  task automatic cpuWrite(input logic [15:0] addr, input logic [15:0] data);
    bus.RW = 1'b0;
    bus.DA = addr;
    tbDd   = data;
    #1;
    checkOutput("ddWritePhase", DD, data);
    tick();
    bus.RW = 1'b1;
    if (refRun) begin
`ifdef MMIO_REG_EN
      if (addr == 16'hFFFF) refOut = data;
      else if (addr != 16'hFFFE) refMem[addr % DEPTH] = data;
`else
      refMem[addr % DEPTH] = data;
`endif
    end
  endtask

  task automatic checkData(input string tag, input logic [15:0] addr);
    bus.RW = 1'b1;
    bus.DA = addr;
    #1;
    checkOutput(tag, DD, refMem[addr % DEPTH]);
  endtask

  task automatic checkInstr(input string tag, input logic [15:0] addr);
    bus.IA = addr;
    #1;
    checkOutput(tag, bus.ID, refMem[addr % DEPTH]);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] c1;
    logic [15:0] c2;
    int          n;

    bus.IA = '0; bus.DA = '0; bus.RW = 1'b1;
    bus.LD_START = 1'b0; bus.LD_VALID = 1'b0; bus.LD_DATA = '0; bus.LD_LAST = 1'b0;
    tbDd = '0;

    // Reset state
    repeat (3) tick();
    checkOutput("rstCpuRst", 16'(CPU_RST), 16'd1);
    checkOutput("rstDone", 16'(LD_DONE), 16'd0);
    checkOutput("rstReady", 16'(bus.LD_READY), 16'd0);
`ifdef MMIO_REG_EN
    checkOutput("rstOutReg", OUT_REG, 16'h0000);
`endif
    RST = 1'b0;
    tick();
    checkOutput("idleReady", 16'(bus.LD_READY), 16'd0);

    // Three-word image with LD_LAST on the third
    startLoad();
    checkOutput("loadReady", 16'(bus.LD_READY), 16'd1);
    checkOutput("loadCpuRst", 16'(CPU_RST), 16'd1);
    applyStimulus(16'hC105, 1'b0, $urandom_range(0, 2));
    applyStimulus(16'hC207, 1'b0, $urandom_range(0, 2));
    checkOutput("preLastCpuRst", 16'(CPU_RST), 16'd1);
    applyStimulus(16'h0312, 1'b1, 0);
    checkOutput("postLastCpuRst", 16'(CPU_RST), 16'd0);
    checkOutput("postLastDone", 16'(LD_DONE), 16'd1);
    checkOutput("postLastReady", 16'(bus.LD_READY), 16'd0);
    for (int i = 0; i < 3; i++) begin
      checkInstr("img3Instr", 16'(i));
      checkData("img3Data", 16'(i));
    end

    // CPU write then read back on the data bus
    cpuWrite(16'h0040, 16'hBEEF);
    checkData("rdBeef", 16'h0040);
    for (int i = 0; i < 20; i++) begin
      addr = 16'($urandom_range(0, 16'hFFFD));
      data = 16'($urandom);
      cpuWrite(addr, data);
      checkData("randData", addr);
      checkInstr("randInstr", addr);
    end

    // Address wrap into the 256-word array
    cpuWrite(16'h0105, 16'h1234);
    checkData("wrapData", 16'h0005);
    checkInstr("wrapInstr", 16'h0005);

    // Full 256-word image with no LD_LAST
    startLoad();
    checkOutput("reloadCpuRst", 16'(CPU_RST), 16'd1);
    checkOutput("reloadDone", 16'(LD_DONE), 16'd0);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(16'($urandom), 1'b0, $urandom_range(0, 1));
    checkOutput("fullPreReady", 16'(bus.LD_READY), 16'd1);
    checkOutput("fullPreDone", 16'(LD_DONE), 16'd0);
    applyStimulus(16'($urandom), 1'b0, 0);
    checkOutput("fullReady", 16'(bus.LD_READY), 16'd0);
    checkOutput("fullDone", 16'(LD_DONE), 16'd1);
    checkOutput("fullCpuRst", 16'(CPU_RST), 16'd0);
    for (int i = 0; i < DEPTH; i++) checkInstr("fullInstr", 16'(i));

    // Reset in the middle of a load
    startLoad();
    applyStimulus(16'hA001, 1'b0, 0);
    applyStimulus(16'hA002, 1'b0, 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    refRun = 1'b0;
    refCnt = 0;
    checkOutput("midRstCpuRst", 16'(CPU_RST), 16'd1);
    checkOutput("midRstReady", 16'(bus.LD_READY), 16'd0);
    checkOutput("midRstDone", 16'(LD_DONE), 16'd0);
    for (int i = 0; i < 4; i++) checkInstr("midRstKeep", 16'(i));
    cpuWrite(16'h0000, 16'hDEAD);
    checkInstr("idleWrIgnored", 16'h0000);
    startLoad();
    applyStimulus(16'h5A5A, 1'b1, 0);
    checkOutput("reloadRun", 16'(CPU_RST), 16'd0);
    checkInstr("reload0", 16'h0000);
    checkInstr("reload1", 16'h0001);

`ifdef MMIO_REG_EN
    // Output register, dropped counter writes and counter rate
    cpuWrite(16'hFFFF, 16'h00A5);
    checkOutput("outReg", OUT_REG, refOut);
    bus.DA = 16'hFFFF;
    #1;
    checkOutput("outRegRead", DD, refOut);
    checkInstr("outRegArray", 16'h00FF);
    cpuWrite(16'hFFFE, 16'h5555);
    checkInstr("cycWrArray", 16'h00FE);
    bus.DA = 16'hFFFE;
    #1;
    c1 = DD;
    n  = $urandom_range(3, 40);
    repeat (n) tick();
    c2 = DD;
    checkOutput("cycDelta", 16'(c2 - c1), 16'(n));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
